// File: rtl/buck_pkg.sv
// buck_pkg: constants and types shared by the buck converter control blocks
// (PWM stage, PID controller, ADC sequencer).
//   CNT_WIDTH        - PWM counter / duty word width
//   MAX_DUTY_DEFAULT - default upper clamp on applied duty
//   DEADTIME_DEFAULT - default dead time in clocks
//   SS_STEP_DEFAULT  - default soft-start increment per period
//   DT_CNT_WIDTH     - dead-time counter width (dead time is below 64)
//   pwm_state_t      - PWM stage operating states
package buck_pkg;

  localparam int CNT_WIDTH        = 10;
  localparam int MAX_DUTY_DEFAULT = 960;
  localparam int DEADTIME_DEFAULT = 8;
  localparam int SS_STEP_DEFAULT  = 4;
  localparam int DT_CNT_WIDTH     = 6;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SOFTSTART = 2'd1,
    RUN       = 2'd2,
    FAULT     = 2'd3
  } pwm_state_t;

endpackage

// File: rtl/deadtime_inserter.sv
// deadtime_inserter: turns the raw PWM level into complementary gate drives,
// holding both gates low for DEADTIME clocks after every raw edge.
// Ports:
//   clk, rst   - clock, async active-high reset
//   raw        - next raw PWM level (registered here as the visible raw)
//   force_off  - holds both gates low and leaves the timer expired
//   hs_gate    - high-side drive (registered)
//   ls_gate    - low-side drive (registered)
module deadtime_inserter #(
  parameter int DEADTIME = buck_pkg::DEADTIME_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic force_off,
  output logic hs_gate,
  output logic ls_gate
);
  import buck_pkg::*;

  // Down-counter loaded with DEADTIME-1 so the gate turns on exactly
  // DEADTIME clocks after the raw edge becomes visible.
  localparam logic [DT_CNT_WIDTH-1:0] DT_LOAD = DT_CNT_WIDTH'(DEADTIME - 1);

  logic                    raw_q;
  logic [DT_CNT_WIDTH-1:0] dt_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raw_q   <= 1'b0;
      dt_cnt  <= '0;
      hs_gate <= 1'b0;
      ls_gate <= 1'b0;
    end else if (force_off) begin
      raw_q   <= 1'b0;
      dt_cnt  <= '0;
      hs_gate <= 1'b0;
      ls_gate <= 1'b0;
    end else begin
      raw_q <= raw;
      if (raw != raw_q) begin
        // edge (also during dead time) restarts the blanking interval
        dt_cnt  <= DT_LOAD;
        hs_gate <= 1'b0;
        ls_gate <= 1'b0;
      end else if (dt_cnt != '0) begin
        dt_cnt  <= dt_cnt - 1'b1;
        hs_gate <= 1'b0;
        ls_gate <= 1'b0;
      end else begin
        hs_gate <= raw;
        ls_gate <= ~raw;
      end
    end
  end

endmodule

// File: rtl/pwm_deadtime_gen.sv
// pwm_deadtime_gen: buck converter PWM stage. Double-buffers the PID duty
// word, applies soft-start and MAX_DUTY clamping, latches faults, and drives
// complementary gates with dead time plus a mid-on-time ADC trigger.
// Ports:
//   clk, rst       - clock, async active-high reset
//   duty_in        - duty word from the PID controller
//   duty_valid     - strobe loading duty_in into the shadow register
//   enable         - run request
//   fault          - level-sensitive fault input
//   hs_gate        - high-side gate drive
//   ls_gate        - low-side gate drive
//   adc_trig       - pulse at cnt == duty_act/2
//   period_start   - pulse at cnt == 0
//   ss_done        - soft-start limit has reached MAX_DUTY
//   fault_latched  - block is in FAULT
//
// state     | meaning
// ----------+-------------------------------------------------------
// IDLE      | gates off, counter/soft-start/active duty cleared
// SOFTSTART | counting, duty limited by a ramp growing each period
// RUN       | counting, duty limited only by MAX_DUTY
// FAULT     | gates off until enable and fault are both low
module pwm_deadtime_gen #(
  parameter int CNT_WIDTH = buck_pkg::CNT_WIDTH,
  parameter int DEADTIME  = buck_pkg::DEADTIME_DEFAULT,
  parameter int MAX_DUTY  = buck_pkg::MAX_DUTY_DEFAULT,
  parameter int SS_STEP   = buck_pkg::SS_STEP_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CNT_WIDTH-1:0] duty_in,
  input  logic                 duty_valid,
  input  logic                 enable,
  input  logic                 fault,
  output logic                 hs_gate,
  output logic                 ls_gate,
  output logic                 adc_trig,
  output logic                 period_start,
  output logic                 ss_done,
  output logic                 fault_latched
);
  import buck_pkg::*;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;
  localparam logic [CNT_WIDTH-1:0] MAX_DUTY_C = CNT_WIDTH'(MAX_DUTY);
  localparam logic [CNT_WIDTH:0]   MAX_DUTY_W = (CNT_WIDTH + 1)'(MAX_DUTY);
  localparam logic [CNT_WIDTH:0]   SS_STEP_W  = (CNT_WIDTH + 1)'(SS_STEP);

  pwm_state_t           state, state_n;
  logic [CNT_WIDTH-1:0] cnt, cnt_n;
  logic [CNT_WIDTH-1:0] shadow;
  logic [CNT_WIDTH-1:0] duty_act, duty_act_n, duty_cap;
  logic [CNT_WIDTH-1:0] ss_limit, ss_limit_n;
  logic [CNT_WIDTH:0]   ss_sum;
  logic                 run_now, run_next, wrap, raw_d;

  always_comb begin
    state_n = state;
    if (fault) begin
      state_n = FAULT;
    end else begin
      case (state)
        IDLE:      if (enable) state_n = SOFTSTART;
        SOFTSTART: if (!enable) state_n = IDLE;
                   else if (ss_limit >= MAX_DUTY_C) state_n = RUN;
        RUN:       if (!enable) state_n = IDLE;
        FAULT:     if (!enable) state_n = IDLE;
        default:   state_n = IDLE;
      endcase
    end
  end

  assign run_now  = (state == SOFTSTART) || (state == RUN);
  assign run_next = (state_n == SOFTSTART) || (state_n == RUN);
  assign wrap     = run_now && (cnt == CNT_MAX);
  assign ss_sum   = {1'b0, ss_limit} + SS_STEP_W;

  // Everything is computed as the value that becomes visible after the edge,
  // so the registered outputs line up with the registered counter.
  always_comb begin
    cnt_n      = '0;
    ss_limit_n = '0;
    duty_act_n = '0;
    duty_cap   = shadow;
    if (duty_cap > MAX_DUTY_C) duty_cap = MAX_DUTY_C;
    if (run_next) begin
      cnt_n      = run_now ? cnt + 1'b1 : '0;
      ss_limit_n = ss_limit;
      if (wrap && state == SOFTSTART)
        ss_limit_n = (ss_sum >= MAX_DUTY_W) ? MAX_DUTY_C : ss_sum[CNT_WIDTH-1:0];
      duty_act_n = duty_act;
      if (wrap) begin
        // the ramp step taken on this wrap already applies to the next period
        if (duty_cap > ss_limit_n) duty_cap = ss_limit_n;
        duty_act_n = duty_cap;
      end
    end
  end

  // raw is high for visible cnt 1..duty_act; the inserter registers it
  assign raw_d = run_next && (cnt < duty_act);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      shadow        <= '0;
      duty_act      <= '0;
      ss_limit      <= '0;
      period_start  <= 1'b0;
      adc_trig      <= 1'b0;
      ss_done       <= 1'b0;
      fault_latched <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      if (duty_valid) shadow <= duty_in;
      duty_act      <= duty_act_n;
      ss_limit      <= ss_limit_n;
      period_start  <= run_next && (cnt_n == '0);
      adc_trig      <= run_next && (cnt_n == (duty_act_n >> 1));
      ss_done       <= ss_limit_n >= MAX_DUTY_C;
      fault_latched <= state_n == FAULT;
    end
  end

  deadtime_inserter #(
    .DEADTIME (DEADTIME)
  ) u_deadtime (
    .clk       (clk),
    .rst       (rst),
    .raw       (raw_d),
    .force_off (~run_next),
    .hs_gate   (hs_gate),
    .ls_gate   (ls_gate)
  );

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
module tb_pwm_deadtime_gen;
  localparam int CW   = 10;
  localparam int PER  = 1024;
  localparam int DT   = 8;
  localparam int MAXD = 960;
  localparam int STEP = 64;

  localparam int M_IDLE = 0, M_SS = 1, M_RUN = 2, M_FAULT = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] din;
  logic          dv, en, flt;
  logic          hs_gate, ls_gate, adc_trig, period_start, ss_done, fault_latched;

  always #5 clk = ~clk;

  pwm_deadtime_gen #(
    .CNT_WIDTH (CW),
    .DEADTIME  (DT),
    .MAX_DUTY  (MAXD),
    .SS_STEP   (STEP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .duty_in       (din),
    .duty_valid    (dv),
    .enable        (en),
    .fault         (flt),
    .hs_gate       (hs_gate),
    .ls_gate       (ls_gate),
    .adc_trig      (adc_trig),
    .period_start  (period_start),
    .ss_done       (ss_done),
    .fault_latched (fault_latched)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: spec-level state, period counter and per-period duty;
  // gate levels come from closed-form windows over the period.
  int m_st, m_cnt, m_duty, m_ss, m_shadow;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_cnt = 0; m_duty = 0; m_ss = 0; m_shadow = 0;
  endtask

  task automatic model_edge();
    bit was_run;
    int nst;
    was_run = (m_st == M_SS) || (m_st == M_RUN);
    if (flt) nst = M_FAULT;
    else if (!en) nst = M_IDLE;
    else if (m_st == M_IDLE) nst = M_SS;
    else if (m_st == M_SS && m_ss >= MAXD) nst = M_RUN;
    else nst = m_st;
    if (!(nst == M_SS || nst == M_RUN)) begin
      m_cnt = 0; m_ss = 0; m_duty = 0;
    end else if (!was_run) begin
      m_cnt = 0;
    end else if (m_cnt == PER - 1) begin
      if (m_st == M_SS) m_ss = imin(m_ss + STEP, MAXD);
      m_duty = imin(imin(m_shadow, MAXD), m_ss);
      m_cnt = 0;
    end else begin
      m_cnt++;
    end
    m_st = nst;
    if (dv) m_shadow = din;
  endtask

  function automatic logic [5:0] model_out();
    bit run, hs, ls;
    run = (m_st == M_SS) || (m_st == M_RUN);
    hs = run && m_duty > DT && m_cnt >= DT + 1 && m_cnt <= m_duty;
    ls = run && (m_cnt == 0 || m_duty == 0 || m_cnt >= m_duty + DT + 1);
    return {m_st == M_FAULT, run && m_ss >= MAXD, run && m_cnt == 0,
            run && m_cnt == m_duty / 2, hs, ls};
  endfunction

  function automatic logic [5:0] dut_out();
    return {fault_latched, ss_done, period_start, adc_trig, hs_gate, ls_gate};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("outputs", dut_out(), model_out());
    check("gate_overlap", hs_gate & ls_gate, 0);
  endtask

  task automatic strobe(input int val);
    din = CW'(val);
    dv = 1'b1;
    tick();
    dv = 1'b0;
  endtask

  task automatic to_cnt(input int target);
    int n;
    n = 0;
    while (m_cnt != target && n < 3 * PER) begin
      tick();
      n++;
    end
    if (m_cnt != target) check("align_timeout", m_cnt, target);
  endtask

  // Called with cnt=1023 visible; observes one full period cnt 0..1023.
  task automatic measure(output int hs_n, output int ls_n, output int adc_at,
                         output int hs_rises);
    logic hs_prev;
    hs_n = 0; ls_n = 0; adc_at = -1; hs_rises = 0;
    hs_prev = hs_gate;
    for (int i = 0; i < PER; i++) begin
      tick();
      if (i == 0) dv = 1'b0;
      if (hs_gate === 1'b1) hs_n++;
      if (ls_gate === 1'b1) ls_n++;
      if (adc_trig === 1'b1) adc_at = i;
      if (hs_gate === 1'b1 && hs_prev !== 1'b1) hs_rises++;
      hs_prev = hs_gate;
    end
  endtask

  task automatic check_period(input string tag, input int duty);
    int hs_n, ls_n, adc_at, rises, dd;
    dd = imin(duty, MAXD);
    measure(hs_n, ls_n, adc_at, rises);
    check({tag, "_hs"}, hs_n, (dd > DT) ? dd - DT : 0);
    check({tag, "_ls"}, ls_n, (dd == 0) ? PER : PER - dd - DT);
    check({tag, "_adc"}, adc_at, dd / 2);
    check({tag, "_hs_pulses"}, rises, (dd > DT) ? 1 : 0);
  endtask

  initial begin
    int n, d, sel;
    rst = 1'b1; en = 1'b0; flt = 1'b0; dv = 1'b0; din = '0;
    model_reset();
    #2;
    check("reset_out", dut_out(), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) tick();

    // soft-start with a clamped shadow value
    strobe(1023);
    en = 1'b1;
    tick();
    n = 0;
    while (ss_done !== 1'b1 && n < 20 * PER) begin
      tick();
      n++;
    end
    check("ss_done_cycles", n, (MAXD / STEP) * PER);
    to_cnt(PER - 1);
    check_period("clamp1023", 1023);

    // steady state at 512
    to_cnt(100);
    strobe(512);
    to_cnt(PER - 1);
    check_period("duty512", 512);

    // double buffering: 300 mid-period, 700 on the cnt=1023 cycle
    to_cnt(400);
    strobe(300);
    to_cnt(PER - 1);
    din = CW'(700);
    dv = 1'b1;
    check_period("dbuf300", 300);
    check_period("dbuf700", 700);

    // extremes
    to_cnt(10);
    strobe(0);
    to_cnt(PER - 1);
    check_period("duty0", 0);
    to_cnt(10);
    strobe(5);
    to_cnt(PER - 1);
    check_period("duty5", 5);

    // random duties strobed at random points in the period
    for (int k = 0; k < 6; k++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0: d = $urandom_range(1, DT);
        1: d = $urandom_range(DT + 1, MAXD);
        2: d = $urandom_range(MAXD, PER - 1);
        default: d = $urandom_range(0, PER - 1);
      endcase
      to_cnt($urandom_range(0, PER - 3));
      strobe(d);
      to_cnt(PER - 1);
      check_period("rand", d);
    end

    // fault during hs_gate high
    to_cnt(50);
    strobe(600);
    to_cnt(PER - 1);
    to_cnt(200);
    check("hs_before_fault", hs_gate, 1);
    flt = 1'b1;
    tick();
    flt = 1'b0;
    check("fault_gates", {hs_gate, ls_gate}, 0);
    check("fault_latch", fault_latched, 1);
    repeat (50) tick();
    check("fault_held", fault_latched, 1);
    en = 1'b0;
    tick();
    check("fault_cleared", fault_latched, 0);
    repeat (3) tick();
    en = 1'b1;
    tick();
    to_cnt(PER - 1);
    check_period("restart_ss", STEP);

    // random enable/fault/duty activity
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) flt = 1'b1;
      else flt = 1'b0;
      if ($urandom_range(0, 699) == 0) en = ~en;
      if ($urandom_range(0, 199) == 0) begin
        din = CW'($urandom_range(0, PER - 1));
        dv = 1'b1;
      end
      tick();
      dv = 1'b0;
    end
    flt = 1'b0;
    en = 1'b1;
    repeat (1500) tick();

    // asynchronous reset mid-period
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_reset_out", dut_out(), 0);
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    tick();
    check("reenter_ss_ls", ls_gate, 1);
    repeat (2 * PER) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pwm_deadtime_gen.md
# pwm_deadtime_gen

Digital PWM stage for the synchronous buck converter, directly downstream of the PID controller. It accepts the controller's 10-bit duty word with a valid strobe and double-buffers it so duty changes only at period boundaries. It generates complementary high-side/low-side gate drives with programmable dead time, applies a soft-start ramp and a latched fault shutdown, and emits an ADC trigger so the feedback path samples mid on-time.

## Interface
- `CNT_WIDTH`, 10: PWM counter width; period = 2^CNT_WIDTH clocks (1024).
- `DEADTIME`, 8: clocks with both gates low after every raw-PWM edge; must satisfy 1 ≤ DEADTIME < 64.
- `MAX_DUTY`, 960: upper clamp on applied duty.
- `SS_STEP`, 4: soft-start limit increment per period.
- `clk` in 1: system clock.
- `rst` in 1: reset. One clock domain; reset is asynchronous and active-high.
- `duty_in` in 10: duty word from the PID controller.
- `duty_valid` in 1: one-cycle strobe; captures `duty_in` into the shadow register.
- `enable` in 1: run request. Low forces IDLE.
- `fault` in 1: overcurrent/overvoltage fault, level-sensitive.
- `hs_gate` out 1: high-side switch drive.
- `ls_gate` out 1: low-side switch drive.
- `adc_trig` out 1: one-cycle ADC start pulse.
- `period_start` out 1: one-cycle pulse at counter value 0.
- `ss_done` out 1: soft-start limit has reached `MAX_DUTY`.
- `fault_latched` out 1: the block is in FAULT.

## Operation
- States: IDLE, SOFTSTART, RUN, FAULT.
  - IDLE → SOFTSTART when `enable`=1 and `fault`=0.
  - SOFTSTART → RUN when `ss_limit` ≥ `MAX_DUTY`.
  - Any state except FAULT → IDLE when `enable`=0.
  - Any state → FAULT when `fault`=1. This takes priority over `enable`.
  - FAULT → IDLE only when `enable`=0 and `fault`=0.
- Counter `cnt`:
  - Free-runs 0..1023 and wraps to 0 in SOFTSTART and RUN.
  - Held at 0 in IDLE and FAULT.
- Shadow register:
  - Loads on `duty_valid` in any state.
  - Reset value is 0.
- Active duty:
  - `duty_act` = min(shadow, `MAX_DUTY`, `ss_limit`).
  - Loads only on the cycle where `cnt`=1023.
  - If `duty_valid` coincides with `cnt`=1023, the new value goes to the shadow register only and takes effect one period later.
- Soft-start limit `ss_limit`:
  - Cleared to 0 in IDLE and FAULT.
  - Increases by `SS_STEP`, saturating at `MAX_DUTY`, on each `cnt`=1023 in SOFTSTART.
  - Holds in RUN.
- Raw PWM: registered as `raw` <= (`cnt` < `duty_act`). It is high for visible `cnt` values 1..`duty_act`.
- Dead time:
  - Every `raw` edge zeroes both gates and restarts the dead-time counter.
  - When the counter reaches `DEADTIME`, `hs_gate`=`raw` and `ls_gate`=!`raw`.
  - An edge during dead time restarts the count.
- Duty boundary cases:
  - Duty 0: `raw` never rises, so `ls_gate` stays continuously high.
  - 0 < duty ≤ `DEADTIME`: `hs_gate` never asserts.
- `adc_trig` pulses when `cnt` = `duty_act`>>1 in SOFTSTART or RUN, so it pulses at `cnt`=0 when duty is 0.
- Gate state outside SOFTSTART and RUN:
  - IDLE and FAULT force both gates low.
  - On entry to SOFTSTART, the dead-time counter starts expired.
- `hs_gate` and `ls_gate` are never high in the same cycle under any input sequence.

## Timing
- All outputs are registered. In reset every output is 0, state is IDLE, and `cnt`, shadow, `duty_act` and `ss_limit` are all 0.
- Assertion of `rst` mid-period drops both gates asynchronously within the same cycle.
- `fault`:
  - Sampled at edge N.
  - Gates are low and `fault_latched`=1 after edge N, i.e. one-cycle shutdown latency.
- Gate positions for duty d > `DEADTIME`:
  - `hs_gate` is high for `cnt` = `DEADTIME`+1..d, which is d−`DEADTIME` clocks.
  - `ls_gate` is high for `cnt` = d+`DEADTIME`+1..1023 and for `cnt` 0, which is 1024−d−`DEADTIME` clocks.
- Duty latency: `duty_valid` to first affected gate edge is at most one full period plus `DEADTIME`+1 clocks.
- `period_start` and `adc_trig` are asserted in the same cycle that `cnt` shows the matching value.

## Structure
- Shared package `buck_pkg`:
  - `CNT_WIDTH`, default `MAX_DUTY` and default `DEADTIME` constants.
  - The `pwm_state_t` enum (IDLE, SOFTSTART, RUN, FAULT).
  - The PID and ADC blocks use the same width constants.
- Sub-module `deadtime_inserter`:
  - Inputs: `clk`, `rst`, `raw`, force-off.
  - Outputs: `hs_gate`, `ls_gate`.
  - Contains the dead-time counter and edge detect.
- The top level holds the FSM, counter, shadow/active registers, soft-start and triggers.

## Test plan
- Steady state: RUN, duty 512, `DEADTIME`=8 → per period `hs_gate` high 504 clocks, `ls_gate` high 504 clocks, both low 16 clocks; `adc_trig` at `cnt`=256.
- Double buffering: `duty_valid` 300 mid-period, then 700 on the `cnt`=1023 cycle → next period uses 300, the following uses 700; no partial pulse.
- Soft-start: `MAX_DUTY`=960, `SS_STEP`=4, shadow 960 → applied duty 4, 8, 12, … on successive periods; `ss_done` rises after 240 periods.
- Clamp and extremes: duty 1023 → 960 applied. Duty 0 → `ls_gate` continuously high, `hs_gate` never high. Duty 5 → `hs_gate` never high.
- Fault: `fault` pulsed one cycle during an `hs_gate` high → both gates low the next cycle; they stay low with `fault_latched`=1 until `enable`=0. Re-enable restarts soft-start from 0.
- Async reset mid-period → all outputs 0 immediately. After release with `enable`=1, the block enters SOFTSTART, and a bench checker flags any cycle with `hs_gate`&`ls_gate`.
